calc_engine: RTL and testbench

Parametrised signed accumulator calculator with an integrated multi-cycle restoring divider, a start/busy/done handshake, and overflow/divide-by-zero status. It sits between the button/switch debounce front end and the display driver, replacing the single-cycle-per-op calculator FSM. Division runs in-engine, one quotient bit per cycle, so no external divider instance is needed.

---
 rtl/calc_engine.sv | 252 +++++++++++++++++++++++++
 tb/tb_calc_engine.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_engine.sv
// rtl/calc_engine.sv - signed accumulator calculator with multi-cycle restoring divider
//
// Ports:
//   clk, reset     clock; synchronous active-high reset
//   start          op request, accepted only while idle
//   buttons[4:0]   op select {UP=MUL, DOWN=CLEAR, LEFT=ADD, RIGHT=SUB, CENTER=DIV}, priority high bit first
//   operand        signed operand, sign-extended to BITS
//   accum, rem     accumulator; remainder of the last successful DIV
//   busy, done     busy from the cycle after acceptance through the done cycle; done is a one-cycle pulse
//   ovf, err_div0  signed overflow of the last op; sticky divide-by-zero
module calc_engine #(
    parameter int BITS = 32,
    parameter int OPW  = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [4:0]      buttons,
    input  logic [OPW-1:0]  operand,
    output logic [BITS-1:0] accum,
    output logic [BITS-1:0] rem,
    output logic            busy,
    output logic            done,
    output logic            ovf,
    output logic            err_div0
);

    localparam int CW = $clog2(BITS) + 1;
    localparam int PW = BITS + OPW;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_DIV_RUN,
        ST_DIV_FIX,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_MUL,
        OP_CLR,
        OP_ADD,
        OP_SUB,
        OP_DIV
    } op_t;

    state_t          state_q, state_d;
    op_t             op_q, op_d;
    logic [BITS-1:0] opnd_q, opnd_d;
    logic [BITS-1:0] accum_q, accum_d;
    logic [BITS-1:0] rem_q, rem_d;
    logic            ovf_q, ovf_d;
    logic            err_q, err_d;
    logic            done_q, done_d;
    logic [BITS-1:0] pr_q, pr_d;   // partial remainder magnitude
    logic [BITS-1:0] dq_q, dq_d;   // dividend bits shifting out, quotient bits shifting in
    logic [BITS-1:0] dv_q, dv_d;   // divisor magnitude
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            a_neg_q, a_neg_d;
    logic            q_neg_q, q_neg_d;

    op_t             op_sel;
    logic [BITS-1:0] opnd_ext;
    logic [BITS-1:0] sum, diff;
    logic            add_ovf, sub_ovf;
    logic [PW-1:0]   mul_a, mul_b, prod;
    logic [OPW:0]    prod_hi;
    logic            mul_ovf;
    logic [BITS-1:0] abs_a, abs_d;
    logic [BITS-1:0] step_pr_in, step_dq_in, step_dv_in;
    logic [BITS:0]   step_sh, step_trial;
    logic [BITS-1:0] step_pr, step_dq;
    logic            step_qbit;

    assign opnd_ext = BITS'($signed(operand));

    always_comb begin
        op_sel = OP_NONE;
        if (buttons[4])      op_sel = OP_MUL;
        else if (buttons[3]) op_sel = OP_CLR;
        else if (buttons[2]) op_sel = OP_ADD;
        else if (buttons[1]) op_sel = OP_SUB;
        else if (buttons[0]) op_sel = OP_DIV;
    end

    // Arithmetic datapath on the latched accumulator/operand.
    always_comb begin
        sum     = accum_q + opnd_q;
        diff    = accum_q - opnd_q;
        add_ovf = (accum_q[BITS-1] == opnd_q[BITS-1]) && (sum[BITS-1] != accum_q[BITS-1]);
        sub_ovf = (accum_q[BITS-1] != opnd_q[BITS-1]) && (diff[BITS-1] != accum_q[BITS-1]);
        // BITS x OPW signed product is exact in BITS+OPW bits; both sides are
        // sign-extended so the unsigned multiply yields the signed result.
        mul_a   = PW'($signed(accum_q));
        mul_b   = PW'($signed(opnd_q[OPW-1:0]));
        prod    = mul_a * mul_b;
        // Representable only if the bits above the result sign all match it.
        prod_hi = prod[PW-1:BITS-1];
        mul_ovf = !((&prod_hi) || !(|prod_hi));
        // Magnitudes are unsigned, so |-2^(BITS-1)| fits without loss.
        abs_a   = accum_q[BITS-1] ? ('0 - accum_q) : accum_q;
        abs_d   = opnd_q[BITS-1] ? ('0 - opnd_q) : opnd_q;
    end

    // One restoring divide step. EXEC performs the first step straight from the
    // magnitudes, so DIV_RUN needs only BITS-1 further steps.
    always_comb begin
        step_pr_in = (state_q == ST_EXEC) ? '0 : pr_q;
        step_dq_in = (state_q == ST_EXEC) ? abs_a : dq_q;
        step_dv_in = (state_q == ST_EXEC) ? abs_d : dv_q;
        step_sh    = {step_pr_in, step_dq_in[BITS-1]};
        step_trial = step_sh - {1'b0, step_dv_in};
        if (step_trial[BITS]) begin
            step_pr   = step_sh[BITS-1:0];
            step_qbit = 1'b0;
        end else begin
            step_pr   = step_trial[BITS-1:0];
            step_qbit = 1'b1;
        end
        step_dq = {step_dq_in[BITS-2:0], step_qbit};
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        opnd_d  = opnd_q;
        accum_d = accum_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        done_d  = 1'b0;
        pr_d    = pr_q;
        dq_d    = dq_q;
        dv_d    = dv_q;
        cnt_d   = cnt_q;
        a_neg_d = a_neg_q;
        q_neg_d = q_neg_q;

        case (state_q)
            ST_IDLE: begin
                // done_q high means the previous op is still in its done cycle.
                if (start && !done_q) begin
                    op_d    = op_sel;
                    opnd_d  = opnd_ext;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_DONE;
                case (op_q)
                    OP_ADD: begin
                        accum_d = sum;
                        ovf_d   = add_ovf;
                    end
                    OP_SUB: begin
                        accum_d = diff;
                        ovf_d   = sub_ovf;
                    end
                    OP_MUL: begin
                        accum_d = prod[BITS-1:0];
                        ovf_d   = mul_ovf;
                    end
                    OP_CLR: begin
                        accum_d = '0;
                        rem_d   = '0;
                        err_d   = 1'b0;
                        ovf_d   = 1'b0;
                    end
                    OP_DIV: begin
                        ovf_d = 1'b0;
                        if (opnd_q == '0) begin
                            err_d = 1'b1;
                        end else begin
                            pr_d    = step_pr;
                            dq_d    = step_dq;
                            dv_d    = abs_d;
                            cnt_d   = CW'(BITS - 1);
                            a_neg_d = accum_q[BITS-1];
                            q_neg_d = accum_q[BITS-1] ^ opnd_q[BITS-1];
                            state_d = ST_DIV_RUN;
                        end
                    end
                    default: ovf_d = 1'b0;
                endcase
            end
            ST_DIV_RUN: begin
                pr_d  = step_pr;
                dq_d  = step_dq;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_DIV_FIX;
                end
            end
            ST_DIV_FIX: begin
                accum_d = q_neg_q ? ('0 - dq_q) : dq_q;
                rem_d   = a_neg_q ? ('0 - pr_q) : pr_q;
                // A magnitude of 2^(BITS-1) with a positive result only arises
                // from -2^(BITS-1) / -1; the wrapped quotient is already correct.
                ovf_d   = dq_q[BITS-1] && !q_neg_q;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NONE;
            opnd_q  <= '0;
            accum_q <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            pr_q    <= '0;
            dq_q    <= '0;
            dv_q    <= '0;
            cnt_q   <= '0;
            a_neg_q <= 1'b0;
            q_neg_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            opnd_q  <= opnd_d;
            accum_q <= accum_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            done_q  <= done_d;
            pr_q    <= pr_d;
            dq_q    <= dq_d;
            dv_q    <= dv_d;
            cnt_q   <= cnt_d;
            a_neg_q <= a_neg_d;
            q_neg_q <= q_neg_d;
        end
    end

    assign accum    = accum_q;
    assign rem      = rem_q;
    assign busy     = (state_q != ST_IDLE) || done_q;
    assign done     = done_q;
    assign ovf      = ovf_q;
    assign err_div0 = err_q;

endmodule

// File: tb/tb_calc_engine.sv
// tb/tb_calc_engine.sv - scoreboard bench for calc_engine with a longint reference model
module tb_calc_engine;

    localparam int BITS = 32;
    localparam int OPW  = 16;
    localparam logic [4:0] B_MUL = 5'b10000;
    localparam logic [4:0] B_CLR = 5'b01000;
    localparam logic [4:0] B_ADD = 5'b00100;
    localparam logic [4:0] B_SUB = 5'b00010;
    localparam logic [4:0] B_DIV = 5'b00001;
    localparam longint ACC_MIN = -(64'sd1 <<< 31);

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [4:0]      buttons;
    logic [OPW-1:0]  operand;
    logic [BITS-1:0] accum;
    logic [BITS-1:0] rem;
    logic            busy;
    logic            done;
    logic            ovf;
    logic            err_div0;

    typedef struct {
        logic [31:0] accum;
        logic [31:0] rem;
        logic        ovf;
        logic        err;
        int          due;
    } exp_t;

    exp_t   sb[$];
    exp_t   mon_e;
    int     n_vec = 0;
    int     n_bad = 0;
    int     cyc = 0;
    longint m_acc, m_rem;
    logic   m_ovf, m_err;

    calc_engine #(.BITS(BITS), .OPW(OPW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .buttons  (buttons),
        .operand  (operand),
        .accum    (accum),
        .rem      (rem),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf),
        .err_div0 (err_div0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint wrap(input longint x);
        return longint'(int'(x));
    endfunction

    task automatic model_reset();
        m_acc = 0;
        m_rem = 0;
        m_ovf = 1'b0;
        m_err = 1'b0;
    endtask

    // Reference behaviour in plain 64-bit arithmetic; lat is edges from accept to done.
    task automatic model_apply(input logic [4:0] b, input logic [OPW-1:0] op, output int lat);
        longint o;
        longint r;
        o   = longint'($signed(op));
        lat = 2;
        if (b[4]) begin
            r     = m_acc * o;
            m_ovf = (r != wrap(r));
            m_acc = wrap(r);
        end else if (b[3]) begin
            m_acc = 0;
            m_rem = 0;
            m_err = 1'b0;
            m_ovf = 1'b0;
        end else if (b[2]) begin
            r     = m_acc + o;
            m_ovf = (r != wrap(r));
            m_acc = wrap(r);
        end else if (b[1]) begin
            r     = m_acc - o;
            m_ovf = (r != wrap(r));
            m_acc = wrap(r);
        end else if (b[0]) begin
            m_ovf = 1'b0;
            if (o == 0) begin
                m_err = 1'b1;
            end else begin
                lat = BITS + 2;
                if (m_acc == ACC_MIN && o == -1) begin
                    m_rem = 0;
                    m_ovf = 1'b1;
                end else begin
                    m_rem = m_acc % o;
                    m_acc = m_acc / o;
                end
            end
        end else begin
            m_ovf = 1'b0;
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting edge.
    task automatic issue(input logic [4:0] b, input logic [OPW-1:0] op);
        int   w;
        int   lat;
        exp_t e;
        w = 0;
        while (busy && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (busy) begin
            n_vec++;
            n_bad++;
            $display("FAIL issue_wait: busy=1 after %0d cycles, required 0", w);
        end
        buttons = b;
        operand = op;
        start   = 1'b1;
        model_apply(b, op, lat);
        e.accum = m_acc[31:0];
        e.rem   = m_rem[31:0];
        e.ovf   = m_ovf;
        e.err   = m_err;
        e.due   = cyc + 1 + lat;
        sb.push_back(e);
        @(negedge clk);
        start   = 1'b0;
        buttons = 5'($urandom);
        operand = OPW'($urandom);
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while ((sb.size() != 0 || busy) && w < BITS * 4) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0 || busy) begin
            n_vec++;
            n_bad++;
            $display("FAIL wait_idle: busy=%0b pending=%0d after %0d cycles, required idle", busy, sb.size(), w);
            sb.delete();
        end
    endtask

    task automatic check_reset_state();
        check("rst_accum", accum, 32'h0);
        check("rst_rem", rem, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_ovf", 32'(ovf), 32'h0);
        check("rst_err", 32'(err_div0), 32'h0);
    endtask

    // Monitor: pops one expectation per done pulse, flags late or spurious done.
    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_done: done=1 with nothing outstanding, required 0 (cycle %0d)", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check("accum", accum, mon_e.accum);
                    check("rem", rem, mon_e.rem);
                    check("ovf", 32'(ovf), 32'(mon_e.ovf));
                    check("err_div0", 32'(err_div0), 32'(mon_e.err));
                    check("busy_at_done", 32'(busy), 32'h1);
                    check("done_cycle", 32'(cyc), 32'(mon_e.due));
                end
            end else if (sb.size() != 0 && cyc > sb[0].due) begin
                n_vec++;
                n_bad++;
                $display("FAIL done_timeout: no done by cycle %0d, required at %0d", cyc, sb[0].due);
                void'(sb.pop_front());
            end
        end
    end

    int          rnd_k;
    logic [4:0]  rnd_b;
    logic [15:0] rnd_op;

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        buttons = 5'b0;
        operand = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_state();
        reset = 1'b0;

        issue(B_ADD, 16'd5);
        issue(B_SUB, 16'd12);
        wait_idle();
        check("add_sub_accum", accum, 32'hFFFF_FFF9);

        issue(B_CLR, 16'd0);
        issue(B_ADD, 16'h4000);
        issue(B_MUL, 16'h4000);
        issue(B_MUL, 16'd8);
        issue(B_SUB, 16'd1);
        issue(B_ADD, 16'd1);
        issue(B_MUL, 16'hFFFF);
        wait_idle();
        check("min_mul_accum", accum, 32'h8000_0000);
        check("min_mul_ovf", 32'(ovf), 32'h1);

        issue(B_CLR, 16'd0);
        issue(B_SUB, 16'd100);
        issue(B_DIV, 16'd7);
        for (int i = 0; i < BITS + 3; i++) begin
            check("div_busy", 32'(busy), 32'h1);
            start   = (i >= 1 && i < 20 && (i % 3) == 1);
            buttons = 5'($urandom);
            operand = OPW'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        wait_idle();
        check("div_accum", accum, 32'hFFFF_FFF2);
        check("div_rem", rem, 32'hFFFF_FFFE);

        issue(B_CLR, 16'd0);
        issue(B_ADD, 16'd42);
        issue(B_DIV, 16'd0);
        wait_idle();
        check("div0_accum", accum, 32'd42);
        check("div0_err", 32'(err_div0), 32'h1);
        issue(B_ADD, 16'd1);
        wait_idle();
        check("div0_sticky", 32'(err_div0), 32'h1);
        issue(B_CLR, 16'd0);
        wait_idle();
        check("clr_err", 32'(err_div0), 32'h0);

        issue(B_ADD, 16'd4);
        issue(B_MUL | B_ADD, 16'd3);
        issue(5'b00000, 16'd77);
        wait_idle();
        check("prio_mul_accum", accum, 32'd12);

        issue(B_ADD, 16'd1000);
        issue(B_DIV, 16'd3);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        check_reset_state();
        reset = 1'b0;
        model_reset();
        issue(B_ADD, 16'd9);
        wait_idle();
        check("post_reset_add", accum, 32'd9);

        for (int i = 0; i < 150; i++) begin
            rnd_k = $urandom_range(0, 11);
            case (rnd_k)
                0, 1:    rnd_b = B_MUL;
                2:       rnd_b = B_CLR;
                3, 4:    rnd_b = B_ADD;
                5, 6:    rnd_b = B_SUB;
                7, 8:    rnd_b = B_DIV;
                9:       rnd_b = 5'b0;
                default: rnd_b = 5'($urandom);
            endcase
            case ($urandom_range(0, 4))
                0:       rnd_op = 16'd0;
                1:       rnd_op = 16'hFFFF;
                2:       rnd_op = 16'($urandom_range(1, 20));
                3:       rnd_op = 16'd0 - 16'($urandom_range(1, 20));
                default: rnd_op = 16'($urandom);
            endcase
            issue(rnd_b, rnd_op);
        end
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
